// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux
//  Purpose  : Routes one upstream valid/ready stream to one of N_OUT
//             downstream valid/ready ports, each with its own one-entry
//             output register. Out-of-range selects are dropped and counted.
//  Revision : 1.0  initial release
// ============================================================================
module stream_demux #(
   parameter  int WIDTH = 8,
   parameter  int N_OUT = 4,
   localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   up_vld,
   input  logic [SEL_W-1:0]       up_sel,
   input  logic [WIDTH-1:0]       up_data,
   output logic                   up_rdy,
   output logic [N_OUT-1:0]       down_vld,
   output logic [N_OUT*WIDTH-1:0] down_data,
   input  logic [N_OUT-1:0]       down_rdy,
   output logic [7:0]             drop_cnt,
   output logic                   busy
);

   // Per-port register occupancy.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } port_state_e;

   logic [N_OUT-1:0] w_sel_hot;   // one-hot decode of up_sel, all-zero when out of range
   logic             w_sel_ok;    // up_sel addresses an existing port
   logic             w_accept;    // upstream handshake this cycle
   logic             w_drop;      // accepted word is discarded
   logic [N_OUT-1:0] w_wr;        // port written this cycle
   logic [N_OUT-1:0] w_drain;     // port consumed downstream this cycle
   logic [7:0]       drop_q;
   logic [7:0]       drop_d;

   // Decode the select; codes at or above N_OUT map to no port at all.
   always_comb begin
      w_sel_hot = '0;
      for (int k = 0; k < N_OUT; k++) begin
         w_sel_hot[k] = (up_sel == SEL_W'(k));
      end
   end

   // Ready depends only on the addressed port: free now, or freed by a
   // drain in this same cycle. Out-of-range words are always taken.
   always_comb begin
      w_sel_ok = |w_sel_hot;
      if (w_sel_ok) begin
         up_rdy = |(w_sel_hot & (~down_vld | down_rdy));
      end else begin
         up_rdy = 1'b1;
      end
      w_accept = up_vld & up_rdy;
      w_wr     = {N_OUT{w_accept}} & w_sel_hot;
      w_drop   = up_vld & ~w_sel_ok;
      w_drain  = down_vld & down_rdy;
   end

   // One-entry register per port; a write in the same cycle as a drain
   // keeps the port full so a ready consumer sees one word per cycle.
   for (genvar k = 0; k < N_OUT; k++) begin : g_port
      port_state_e      state_q;
      logic [WIDTH-1:0] data_q;

      // Port occupancy and payload update.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
         end else if (w_wr[k]) begin
            state_q <= ST_FULL;
            data_q  <= up_data;
         end else if (w_drain[k]) begin
            state_q <= ST_EMPTY;
         end
      end

      assign down_vld[k]                    = (state_q == ST_FULL);
      assign down_data[k*WIDTH +: WIDTH]    = data_q;
   end

   // Saturating count of discarded words.
   always_comb begin
      drop_d = drop_q;
      if (w_drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 8'd0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
   assign busy     = |down_vld;

endmodule
`default_nettype wire
